// File: rtl/chacha20_pkg.sv
// Shared types and helpers for the ChaCha20 keystream XOR stage.
package chacha20_pkg;

  localparam int unsigned CHACHA_WORDS = 16;

  typedef logic [31:0]                 word_t;
  typedef logic [32*CHACHA_WORDS-1:0]  block_t;
  typedef logic [255:0]                key_t;
  typedef logic [95:0]                 nonce_t;
  typedef logic [3:0]                  idx_t;
  typedef logic [2:0]                  state_t;

  localparam state_t StIdle   = 3'd0;
  localparam state_t StReq    = 3'd1;
  localparam state_t StWait   = 3'd2;
  localparam state_t StStream = 3'd3;
  localparam state_t StFlush  = 3'd4;

  // Word 0 sits in the most significant 32 bits of the block.
  function automatic word_t ks_word(block_t blk, idx_t idx);
    return blk[$bits(block_t) - 1 - 32 * int'(idx) -: 32];
  endfunction

endpackage

// File: rtl/chacha20_out_reg.sv
// One-deep output register: loads on an input accept, holds while downstream stalls.
module chacha20_out_reg
  import chacha20_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic [31:0] data_i,
  input  logic [3:0]  keep_i,
  input  logic        last_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] data_o,
  output logic [3:0]  keep_o,
  output logic        last_o
);

  logic       valid_q, valid_d;
  word_t      data_q;
  logic [3:0] keep_q;
  logic       last_q;

  // A reload in the same cycle as a drain keeps the register full.
  always_comb begin
    valid_d = valid_q;
    if (ready_i) valid_d = 1'b0;
    if (load_i)  valid_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (load_i) begin
        data_q <= data_i;
        keep_q <= keep_i;
        last_q <= last_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign keep_o  = keep_q;
  assign last_o  = last_q;

endmodule

// File: rtl/chacha20_stream_xor.sv
// ChaCha20 keystream XOR stage: fetches one 512-bit block at a time from the core and
// XORs it into a 32-bit valid/ready data stream, advancing the block counter per block.
module chacha20_stream_xor
  import chacha20_pkg::*;
#(
  parameter int unsigned NUM_WORDS = CHACHA_WORDS
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         msg_start_i,
  input  logic [255:0] cfg_key_i,
  input  logic [95:0]  cfg_nonce_i,
  input  logic [31:0]  cfg_counter_i,
  output logic         core_start_o,
  output logic [255:0] core_key_o,
  output logic [95:0]  core_nonce_o,
  output logic [31:0]  core_counter_o,
  input  logic         core_busy_i,
  input  logic         core_done_i,
  input  logic [511:0] core_state_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [31:0]  in_data_i,
  input  logic [3:0]   in_keep_i,
  input  logic         in_last_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [31:0]  out_data_o,
  output logic [3:0]   out_keep_o,
  output logic         out_last_o,
  output logic         busy_o,
  output logic         msg_done_o,
  output logic         ctr_err_o
);

  state_t state_q, state_d;
  key_t   key_q, key_d;
  nonce_t nonce_q, nonce_d;
  word_t  ctr_q, ctr_d;
  block_t ks_buf_q, ks_buf_d;
  idx_t   idx_q, idx_d;
  logic   ctr_err_q, ctr_err_d;

  logic       in_accept;
  logic [3:0] keep_eff;
  word_t      byte_mask;
  word_t      xored;

  // The core's busy flag is not needed: a block is only requested after the last one landed.
  logic unused_core_busy;
  assign unused_core_busy = core_busy_i;

  assign in_ready_o = (state_q == StStream) & (~out_valid_o | out_ready_i);
  assign in_accept  = in_valid_i & in_ready_o;

  // Byte enables only qualify the final word; earlier words are always full.
  always_comb begin
    keep_eff = in_last_i ? in_keep_i : 4'hF;
    for (int b = 0; b < 4; b++) begin
      byte_mask[8*b +: 8] = {8{keep_eff[b]}};
    end
    xored = (in_data_i ^ ks_word(ks_buf_q, idx_q)) & byte_mask;
  end

  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    nonce_d   = nonce_q;
    ctr_d     = ctr_q;
    ks_buf_d  = ks_buf_q;
    idx_d     = idx_q;
    ctr_err_d = ctr_err_q;
    case (state_q)
      StIdle: begin
        if (msg_start_i) begin
          key_d     = cfg_key_i;
          nonce_d   = cfg_nonce_i;
          ctr_d     = cfg_counter_i;
          ctr_err_d = 1'b0;
          idx_d     = '0;
          state_d   = StReq;
        end
      end
      StReq: state_d = StWait;
      StWait: begin
        if (core_done_i) begin
          ks_buf_d = core_state_i;
          idx_d    = '0;
          state_d  = StStream;
        end
      end
      StStream: begin
        if (in_accept) begin
          idx_d = idx_q + idx_t'(1);
          if (in_last_i) begin
            state_d = StFlush;
          end else if (idx_q == idx_t'(NUM_WORDS - 1)) begin
            // A block past counter 0xFFFFFFFF would repeat keystream; stop instead.
            if (ctr_q == 32'hFFFF_FFFF) begin
              ctr_err_d = 1'b1;
              state_d   = StFlush;
            end else begin
              ctr_d   = ctr_q + 32'd1;
              state_d = StReq;
            end
          end
        end
      end
      StFlush: begin
        if (out_valid_o && out_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      key_q     <= '0;
      nonce_q   <= '0;
      ctr_q     <= '0;
      ks_buf_q  <= '0;
      idx_q     <= '0;
      ctr_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      key_q     <= key_d;
      nonce_q   <= nonce_d;
      ctr_q     <= ctr_d;
      ks_buf_q  <= ks_buf_d;
      idx_q     <= idx_d;
      ctr_err_q <= ctr_err_d;
    end
  end

  chacha20_out_reg u_out_reg (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (in_accept),
    .data_i  (xored),
    .keep_i  (in_keep_i),
    .last_i  (in_last_i),
    .ready_i (out_ready_i),
    .valid_o (out_valid_o),
    .data_o  (out_data_o),
    .keep_o  (out_keep_o),
    .last_o  (out_last_o)
  );

  assign core_start_o   = (state_q == StReq);
  assign core_key_o     = key_q;
  assign core_nonce_o   = nonce_q;
  assign core_counter_o = ctr_q;
  assign busy_o         = (state_q != StIdle);
  assign msg_done_o     = (state_q == StFlush) & out_valid_o & out_ready_i;
  assign ctr_err_o      = ctr_err_q;

endmodule

// File: tb/tb_chacha20_stream_xor.sv
// Bench for chacha20_stream_xor with a behavioural ChaCha20 core and directed vectors.
module tb_chacha20_stream_xor;

  localparam logic [255:0] KEY = {32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
                                  32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c};
  localparam logic [95:0] NONCE = {32'h00000000, 32'h4a000000, 32'h00000000};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, msg_start;
  logic [255:0] cfg_key;
  logic [95:0]  cfg_nonce;
  logic [31:0]  cfg_counter;
  logic         core_start, core_busy, core_done;
  logic [255:0] core_key;
  logic [95:0]  core_nonce;
  logic [31:0]  core_counter;
  logic [511:0] core_state;
  logic         in_valid, in_ready, in_last;
  logic [31:0]  in_data;
  logic [3:0]   in_keep;
  logic         out_valid, out_ready, out_last;
  logic [31:0]  out_data;
  logic [3:0]   out_keep;
  logic         busy, msg_done, ctr_err;

  int checks = 0;
  int failures = 0;

  chacha20_stream_xor dut (
    .clk_i(clk), .rst_ni(rst_n), .msg_start_i(msg_start),
    .cfg_key_i(cfg_key), .cfg_nonce_i(cfg_nonce), .cfg_counter_i(cfg_counter),
    .core_start_o(core_start), .core_key_o(core_key), .core_nonce_o(core_nonce),
    .core_counter_o(core_counter), .core_busy_i(core_busy), .core_done_i(core_done),
    .core_state_i(core_state), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_data_i(in_data), .in_keep_i(in_keep), .in_last_i(in_last),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_keep_o(out_keep), .out_last_o(out_last), .busy_o(busy),
    .msg_done_o(msg_done), .ctr_err_o(ctr_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- ChaCha20 reference ----------------
  function automatic logic [31:0] rotl(logic [31:0] v, int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [127:0] qr(logic [31:0] a, logic [31:0] b, logic [31:0] c,
                                      logic [31:0] d);
    a = a + b; d = rotl(d ^ a, 16);
    c = c + d; b = rotl(b ^ c, 12);
    a = a + b; d = rotl(d ^ a, 8);
    c = c + d; b = rotl(b ^ c, 7);
    return {a, b, c, d};
  endfunction

  function automatic logic [511:0] chacha_block(logic [255:0] k, logic [95:0] n,
                                                logic [31:0] c);
    logic [31:0]  s[16];
    logic [31:0]  x[16];
    logic [511:0] r;
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4+i] = k[255-32*i -: 32];
    s[12] = c;
    for (int i = 0; i < 3; i++) s[13+i] = n[95-32*i -: 32];
    x = s;
    for (int rd = 0; rd < 10; rd++) begin
      {x[0], x[4], x[8],  x[12]} = qr(x[0], x[4], x[8],  x[12]);
      {x[1], x[5], x[9],  x[13]} = qr(x[1], x[5], x[9],  x[13]);
      {x[2], x[6], x[10], x[14]} = qr(x[2], x[6], x[10], x[14]);
      {x[3], x[7], x[11], x[15]} = qr(x[3], x[7], x[11], x[15]);
      {x[0], x[5], x[10], x[15]} = qr(x[0], x[5], x[10], x[15]);
      {x[1], x[6], x[11], x[12]} = qr(x[1], x[6], x[11], x[12]);
      {x[2], x[7], x[8],  x[13]} = qr(x[2], x[7], x[8],  x[13]);
      {x[3], x[4], x[9],  x[14]} = qr(x[3], x[4], x[9],  x[14]);
    end
    for (int i = 0; i < 16; i++) r[511-32*i -: 32] = x[i] + s[i];
    return r;
  endfunction

  // ---------------- behavioural core ----------------
  logic         pend = 1'b0;
  logic         done_q = 1'b0;
  int           lat = 0;
  logic [511:0] blk_q = '0;
  logic         spur_done;

  always @(negedge clk) begin
    done_q <= 1'b0;
    if (core_start) begin
      pend  <= 1'b1;
      lat   <= 2;
      blk_q <= chacha_block(core_key, core_nonce, core_counter);
    end else if (pend) begin
      if (lat == 0) begin
        done_q <= 1'b1;
        pend   <= 1'b0;
      end else begin
        lat <= lat - 1;
      end
    end
  end

  assign core_busy  = pend;
  assign core_done  = done_q | spur_done;
  assign core_state = spur_done ? {16{32'hDEADBEEF}} : blk_q;

  // ---------------- output readiness ----------------
  bit rand_ready;
  bit ready_level;
  initial begin
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_level;
    end
  end

  // ---------------- monitor ----------------
  logic [31:0] got_data[$];
  logic [3:0]  got_keep[$];
  logic        got_last[$];
  logic [31:0] in_ctr[$];
  int          starts, dones;
  bit          prev_stall = 0;
  logic [37:0] prev_beat = '0;

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        prev_stall = 0;
      end else begin
        if (prev_stall)
          chk("hold_stall", {26'b0, out_valid, out_data, out_keep, out_last},
              {26'b0, prev_beat});
        prev_stall = out_valid && !out_ready;
        prev_beat  = {1'b1, out_data, out_keep, out_last};
        if (out_valid && out_ready) begin
          got_data.push_back(out_data);
          got_keep.push_back(out_keep);
          got_last.push_back(out_last);
        end
        if (in_valid && in_ready) in_ctr.push_back(core_counter);
        if (msg_done) dones++;
        if (core_start) starts++;
      end
    end
  end

  task automatic clear_mon();
    got_data.delete(); got_keep.delete(); got_last.delete(); in_ctr.delete();
    starts = 0;
    dones  = 0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic [31:0] exp_data;
    logic [3:0]  exp_keep;
    logic        exp_last;
  } vec_t;
  vec_t vec[$];

  // mode 0: RFC 8439 plaintext, 1: zeros, 2: byte ramp
  task automatic build_vec(input int mode, input int nbytes, input bit with_last,
                           input logic [31:0] ctr0);
    string       pt;
    int          nw;
    pt = {"Ladies and Gentlemen of the class of '99: If I could offer you only one tip ",
          "for the future, sunscreen would be it."};
    vec.delete();
    nw = (nbytes + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      vec_t         v;
      logic [511:0] blk;
      logic [31:0]  ks, mask;
      int           rem;
      v.data = '0;
      for (int b = 0; b < 4; b++) begin
        int p;
        p = 4 * w + b;
        if (p < nbytes) begin
          if (mode == 0)      v.data[8*b +: 8] = pt[p];
          else if (mode == 1) v.data[8*b +: 8] = 8'h00;
          else                v.data[8*b +: 8] = 8'(p * 7 + 3);
        end
      end
      v.last = with_last && (w == nw - 1);
      rem    = nbytes - 4 * w;
      v.keep = (v.last && rem < 4) ? 4'((1 << rem) - 1) : 4'hF;
      blk    = chacha_block(KEY, NONCE, ctr0 + 32'(w / 16));
      ks     = blk[511 - 32 * (w % 16) -: 32];
      for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{v.keep[b]}};
      v.exp_data = (v.data ^ ks) & mask;
      v.exp_keep = v.keep;
      v.exp_last = v.last;
      vec.push_back(v);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic start_msg(input logic [31:0] ctr);
    @(negedge clk);
    cfg_counter = ctr;
    msg_start   = 1'b1;
    @(negedge clk);
    msg_start   = 1'b0;
  endtask

  task automatic send_word(input vec_t v, input int maxw, output bit ok);
    int w;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = v.data;
    in_keep  = v.keep;
    in_last  = v.last;
    #1;
    w = 0;
    while (!in_ready && w < maxw) begin
      @(negedge clk);
      #1;
      w++;
    end
    ok = in_ready;
    if (ok) @(posedge clk);
  endtask

  task automatic send_range(input int lo, input int hi, input int maxw, output int n_acc);
    bit ok;
    n_acc = 0;
    for (int i = lo; i <= hi; i++) begin
      send_word(vec[i], maxw, ok);
      if (!ok) break;
      n_acc++;
    end
  endtask

  task automatic finish_in();
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out(input string tag, input int n);
    int cyc;
    cyc = 0;
    while (got_data.size() < n && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    while (busy && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    #3;
    chk({tag, "_out_count"}, got_data.size(), n);
    chk({tag, "_idle"}, busy, 1'b0);
  endtask

  task automatic cmp_vec(input string tag, input int n);
    for (int i = 0; i < n && i < got_data.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), got_data[i], vec[i].exp_data);
      chk($sformatf("%s_keep%0d", tag, i), got_keep[i], vec[i].exp_keep);
      chk($sformatf("%s_last%0d", tag, i), got_last[i], vec[i].exp_last);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n;
    rst_n = 1'b0; msg_start = 1'b0; spur_done = 1'b0;
    cfg_key = KEY; cfg_nonce = NONCE; cfg_counter = 32'h1;
    in_valid = 1'b0; in_data = '0; in_keep = '0; in_last = 1'b0;
    rand_ready = 0; ready_level = 1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_keep", out_keep, 4'h0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_msg_done", msg_done, 1'b0);
    chk("rst_ctr_err", ctr_err, 1'b0);
    chk("rst_core_start", core_start, 1'b0);
    chk("rst_core_key_zero", 64'(core_key == '0), 64'd1);
    chk("rst_core_nonce_zero", 64'(core_nonce == '0), 64'd1);
    chk("rst_core_counter", core_counter, 32'h0);
    rst_n = 1'b1;

    // RFC 8439 2.4.2 vector, downstream always ready
    build_vec(0, 114, 1, 32'h1);
    clear_mon();
    start_msg(32'h1);
    send_range(0, vec.size() - 1, 100, n);
    finish_in();
    chk("rfc_accepted", n, 29);
    wait_out("rfc", 29);
    cmp_vec("rfc", 29);
    if (got_data.size() > 0) chk("rfc_word0", got_data[0], 32'h9a352e6e);
    if (got_keep.size() == 29) chk("rfc_last_keep", got_keep[28], 4'b0011);
    chk("rfc_msg_done", dones, 1);
    chk("rfc_ctr_err", ctr_err, 1'b0);
    chk("rfc_core_starts", starts, 2);

    // 17 zero words; msg_start and a spurious core_done mid-stream must be ignored
    build_vec(1, 68, 1, 32'h1);
    clear_mon();
    start_msg(32'h1);
    send_range(0, 4, 100, n);
    @(negedge clk);
    in_valid = 1'b0; msg_start = 1'b1; cfg_counter = 32'd99; spur_done = 1'b1;
    @(negedge clk);
    msg_start = 1'b0; spur_done = 1'b0; cfg_counter = 32'h1;
    send_range(5, 16, 100, n);
    finish_in();
    chk("zero_accepted_tail", n, 12);
    wait_out("zero", 17);
    cmp_vec("zero", 17);
    if (got_data.size() > 0) chk("zero_word0", got_data[0], 32'hf3514f22);
    if (in_ctr.size() == 17) begin
      chk("zero_ctr_w0", in_ctr[0], 32'd1);
      chk("zero_ctr_w5", in_ctr[5], 32'd1);
      chk("zero_ctr_w16", in_ctr[16], 32'd2);
    end else begin
      chk("zero_in_count", in_ctr.size(), 17);
    end
    chk("zero_core_starts", starts, 2);
    chk("zero_msg_done", dones, 1);

    // RFC vector with random backpressure
    rand_ready = 1;
    build_vec(0, 114, 1, 32'h1);
    clear_mon();
    start_msg(32'h1);
    send_range(0, vec.size() - 1, 200, n);
    finish_in();
    chk("rand_accepted", n, 29);
    wait_out("rand", 29);
    rand_ready = 0;
    cmp_vec("rand", 29);
    chk("rand_msg_done", dones, 1);

    // counter wrap: block after 0xFFFFFFFF must not be requested
    build_vec(1, 80, 0, 32'hFFFF_FFFF);
    clear_mon();
    start_msg(32'hFFFF_FFFF);
    send_range(0, 19, 40, n);
    chk("wrap_accepted", n, 16);
    chk("wrap_in_ready", in_ready, 1'b0);
    finish_in();
    wait_out("wrap", 16);
    cmp_vec("wrap", 16);
    chk("wrap_ctr_err", ctr_err, 1'b1);
    chk("wrap_msg_done", dones, 1);
    chk("wrap_core_starts", starts, 1);

    // reset while waiting on the core; msg_start also clears ctr_err
    clear_mon();
    start_msg(32'd7);
    chk("wait_ctr_err_cleared", ctr_err, 1'b0);
    for (int c = 0; c < 50 && starts == 0; c++) @(negedge clk);
    chk("wait_core_started", starts, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("wait_rst_busy", busy, 1'b0);
    chk("wait_rst_core_counter", core_counter, 32'h0);
    chk("wait_rst_core_key_zero", 64'(core_key == '0), 64'd1);
    chk("wait_rst_in_ready", in_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("wait_late_done_ignored", busy, 1'b0);

    // reset mid-stream with a stalled output beat, then a clean message
    ready_level = 0;
    build_vec(2, 11, 1, 32'd3);
    clear_mon();
    start_msg(32'd3);
    send_range(0, 0, 50, n);
    @(negedge clk);
    #1;
    chk("mid_stall_valid", out_valid, 1'b1);
    chk("mid_stall_data", out_data, vec[0].exp_data);
    chk("mid_stall_in_ready", in_ready, 1'b0);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_out_data", out_data, 32'h0);
    chk("mid_rst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    ready_level = 1;
    repeat (2) @(negedge clk);
    clear_mon();
    start_msg(32'd3);
    send_range(0, vec.size() - 1, 100, n);
    finish_in();
    wait_out("clean", 3);
    cmp_vec("clean", 3);
    chk("clean_msg_done", dones, 1);
    chk("clean_ctr_err", ctr_err, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
